// File: rtl/dap_swd_seq_ctrl_if.sv
// dap_swd_seq_ctrl_if: dispatcher, packet and sequencer handshakes of the SWD sequence controller
interface dap_swd_seq_ctrl_if;
  logic        start;
  logic        busy;
  logic        done;
  logic        req_valid;
  logic [7:0]  req_data;
  logic        req_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_ready;
  logic        seq_tx_valid;
  logic [15:0] seq_tx_cmd;
  logic [63:0] seq_tx_data;
  logic        seq_rx_valid;
  logic [63:0] seq_rx_data;
  modport master (
    output start, req_valid, req_data, rsp_ready, seq_rx_valid, seq_rx_data,
    input  busy, done, req_ready, rsp_valid, rsp_data, seq_tx_valid, seq_tx_cmd, seq_tx_data
  );
  modport slave (
    input  start, req_valid, req_data, rsp_ready, seq_rx_valid, seq_rx_data,
    output busy, done, req_ready, rsp_valid, rsp_data, seq_tx_valid, seq_tx_cmd, seq_tx_data
  );
endinterface

// File: rtl/dap_swd_seq_ctrl.sv
// dap_swd_seq_ctrl: executes one DAP_SWD_Sequence request, one sequencer command per sequence
module dap_swd_seq_ctrl #(
  parameter logic [3:0] CMD_SWD_SEQ = 4'd2,
  parameter int         GAP_CYCLES  = 8
) (
  input logic clk,
  input logic reset,
  dap_swd_seq_ctrl_if.slave bus
);
  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam logic [3:0] IDLE = 4'd0, RSP_ID = 4'd1, RSP_ST = 4'd2, GET_CNT = 4'd3,
                         GET_INFO = 4'd4, GET_DATA = 4'd5, ISSUE = 4'd6, WAIT_RX = 4'd7,
                         GAP = 4'd8, PUT_DATA = 4'd9, NEXT = 4'd10, DONE = 4'd11;
  logic [3:0]    state, k, nbytes;
  logic [7:0]    seq_left, rev_byte;
  logic [GW-1:0] gap_cnt;
  logic [6:0]    n;
  logic          dir_in, rx_q, tx_act, last_byte, rx_rise;
  logic [63:0]   tx_buf, rx_buf, rsp_shift, rsp_vec;
  always_comb begin
    nbytes    = 4'((n + 7'd7) >> 3);
    last_byte = k == nbytes - 4'd1;
    rx_rise   = bus.seq_rx_valid & ~rx_q;
    tx_act    = state == ISSUE || state == WAIT_RX;
    rsp_shift = rx_buf << (7'd64 - n);
    for (int i = 0; i < 64; i++) rsp_vec[i] = rsp_shift[63-i];
    for (int i = 0; i < 8; i++) rev_byte[i] = bus.req_data[7-i];
  end
  always_comb begin
    bus.busy         = state != IDLE && state != DONE;
    bus.done         = state == DONE;
    bus.req_ready    = state == GET_CNT || state == GET_INFO || state == GET_DATA;
    bus.rsp_valid    = state == RSP_ID || state == RSP_ST || state == PUT_DATA;
    bus.rsp_data     = state == RSP_ID ? 8'h1D : state == PUT_DATA ? rsp_vec[{k[2:0], 3'b000} +: 8] : 8'h00;
    bus.seq_tx_valid = tx_act;
    bus.seq_tx_cmd   = tx_act ? {CMD_SWD_SEQ, 4'h0, dir_in, n} : 16'h0;
    bus.seq_tx_data  = tx_act ? tx_buf & ~({64{1'b1}} >> n) : 64'h0;
  end
  // first wire bit of each request byte lands at the top of its lane
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      k        <= '0;
      seq_left <= '0;
      gap_cnt  <= '0;
      n        <= '0;
      dir_in   <= 1'b0;
      rx_q     <= 1'b0;
      tx_buf   <= '0;
      rx_buf   <= '0;
    end else begin
      rx_q <= bus.seq_rx_valid;
      case (state)
        IDLE:     if (bus.start) state <= RSP_ID;
        RSP_ID:   if (bus.rsp_ready) state <= RSP_ST;
        RSP_ST:   if (bus.rsp_ready) state <= GET_CNT;
        GET_CNT:  if (bus.req_valid) begin
          seq_left <= bus.req_data;
          state    <= bus.req_data == 8'd0 ? DONE : GET_INFO;
        end
        GET_INFO: if (bus.req_valid) begin
          n      <= {bus.req_data[5:0] == 6'd0, bus.req_data[5:0]};
          dir_in <= bus.req_data[7];
          tx_buf <= '0;
          k      <= '0;
          state  <= bus.req_data[7] ? ISSUE : GET_DATA;
        end
        GET_DATA: if (bus.req_valid) begin
          tx_buf <= tx_buf | ({rev_byte, 56'h0} >> {k[2:0], 3'b000});
          k      <= last_byte ? 4'd0 : k + 4'd1;
          state  <= last_byte ? ISSUE : GET_DATA;
        end
        ISSUE:    state <= WAIT_RX;
        WAIT_RX:  if (rx_rise) begin
          rx_buf  <= bus.seq_rx_data;
          gap_cnt <= GW'(GAP_CYCLES);
          state   <= GAP;
        end
        GAP:      if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
                  else if (!bus.seq_rx_valid) state <= dir_in ? PUT_DATA : NEXT;
        PUT_DATA: if (bus.rsp_ready) begin
          k     <= last_byte ? 4'd0 : k + 4'd1;
          state <= last_byte ? NEXT : PUT_DATA;
        end
        NEXT: begin
          seq_left <= seq_left - 8'd1;
          state    <= seq_left == 8'd1 ? DONE : GET_INFO;
        end
        DONE:     state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dap_swd_seq_ctrl.sv
// tb_dap_swd_seq_ctrl: randomized requests against a bit-level model of the SWD sequence command
module tb_dap_swd_seq_ctrl;
  localparam int GAP = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  dap_swd_seq_ctrl_if bus();
  dap_swd_seq_ctrl #(.CMD_SWD_SEQ(4'd2), .GAP_CYCLES(GAP)) dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0, errors = 0;
  logic [7:0]  exp_rsp[$];
  logic [15:0] exp_cmd[$];
  logic [63:0] exp_txd[$], rx_vals[$];
  int          g_n[$];
  bit          g_dir[$];
  logic [63:0] g_w[$], g_rx[$];
  bit rsp_hold = 0, hold_rx = 0;
  int done_cnt = 0, tx_rises = 0;
  bit tx_prev = 0, pv = 0, pacc = 0, tvp = 0;
  int rw = 0, rh = 0, low = 1000;
  logic [63:0] rv = '0, tdata = '0;
  logic [15:0] tcmd = '0;
  logic [7:0]  pd = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event, expected none pending", name);
  endtask

  // wire bit b of an output sequence goes out first-at-top: data[63-b]
  function automatic logic [63:0] m_txdata(input int n, input logic [63:0] w);
    logic [63:0] e = '0;
    for (int b = 0; b < n; b++) e[63-b] = w[b];
    return e;
  endfunction

  // response bit i is the i-th captured wire bit; rx holds the last one at [0]
  function automatic logic [7:0] m_rspbyte(input int n, input logic [63:0] rx, input int k);
    logic [7:0] v = '0;
    for (int j = 0; j < 8; j++) if (8*k + j < n) v[j] = rx[n-1-(8*k+j)];
    return v;
  endfunction

  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.rsp_ready = !rsp_hold && ($urandom_range(0, 3) != 0);
    end
  end

  // sequencer stand-in: checks each command and answers with a multi-cycle result strobe
  initial begin
    bus.seq_rx_valid = 1'b0;
    bus.seq_rx_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        rw = 0; rh = 0; tx_prev = 0;
        bus.seq_rx_valid = 1'b0;
      end else begin
        if (bus.seq_tx_valid && !tx_prev) begin
          tx_rises++;
          if (exp_cmd.size() == 0) miss("tx_unexpected");
          else begin
            logic [15:0] c;
            logic [63:0] d;
            c = exp_cmd.pop_front();
            d = exp_txd.pop_front();
            chk("tx_cmd", bus.seq_tx_cmd, c);
            if (!c[7]) chk("tx_data", bus.seq_tx_data, d);
            rv = rx_vals.pop_front();
            rw = hold_rx ? 0 : $urandom_range(1, 5);
            rh = $urandom_range(1, 4);
          end
        end else if (rw > 0) begin
          rw--;
          if (rw == 0) begin
            bus.seq_rx_valid = 1'b1;
            bus.seq_rx_data  = rv;
          end
        end else if (rh > 0 && bus.seq_rx_valid) begin
          rh--;
          if (rh == 0) begin
            bus.seq_rx_valid = 1'b0;
            bus.seq_rx_data  = {$urandom, $urandom};
          end
        end
        tx_prev = bus.seq_tx_valid;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        pv = 0; tvp = 0; low = 1000;
      end else begin
        if (bus.rsp_valid && pv && !pacc) chk("rsp_stable", bus.rsp_data, pd);
        if (bus.rsp_valid && bus.rsp_ready) begin
          if (exp_rsp.size() == 0) miss("rsp_extra");
          else chk("rsp_byte", bus.rsp_data, exp_rsp.pop_front());
        end
        pv = bus.rsp_valid; pd = bus.rsp_data; pacc = bus.rsp_ready;
        if (bus.seq_tx_valid && tvp) begin
          chk("tx_hold_cmd", bus.seq_tx_cmd, tcmd);
          chk("tx_hold_data", bus.seq_tx_data, tdata);
        end
        if (bus.seq_tx_valid && !tvp) begin
          checks++;
          if (low < GAP) begin
            errors++;
            $display("FAIL tx_gap: got %0d low cycles, expected at least %0d", low, GAP);
          end
        end
        low = bus.seq_tx_valid ? 0 : low + 1;
        tvp = bus.seq_tx_valid; tcmd = bus.seq_tx_cmd; tdata = bus.seq_tx_data;
        if (bus.done) begin
          done_cnt++;
          low = 1000;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    bus.req_valid = 1'b1;
    bus.req_data  = b;
    forever begin
      @(negedge clk);
      if (bus.req_ready) break;
      if (++t > 3000) begin
        chk("req_timeout", 64'(t), 0);
        break;
      end
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_data  = 8'($urandom);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic run_txn(input bit dbl_start);
    logic [7:0] req[$];
    int d0, r0, t, ns;
    ns = g_n.size();
    req.push_back(8'(ns));
    exp_rsp.push_back(8'h1D);
    exp_rsp.push_back(8'h00);
    foreach (g_n[s]) begin
      int n;
      logic [63:0] w;
      n = g_n[s];
      w = g_w[s];
      req.push_back({g_dir[s], 1'($urandom), 6'(n)});
      exp_cmd.push_back({4'd2, 4'h0, g_dir[s], 7'(n)});
      exp_txd.push_back(m_txdata(n, w));
      rx_vals.push_back(g_rx[s]);
      for (int k = 0; k < (n + 7) / 8; k++)
        if (g_dir[s]) exp_rsp.push_back(m_rspbyte(n, g_rx[s], k));
        else req.push_back(w[8*k +: 8]);
    end
    d0 = done_cnt;
    r0 = tx_rises;
    pulse_start();
    if (dbl_start) begin
      @(posedge clk); #1;
      pulse_start();
    end
    foreach (req[i]) send_byte(req[i]);
    t = 0;
    while (done_cnt == d0 && t < 5000) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    chk("done_once", 64'(done_cnt - d0), 1);
    chk("tx_pulses", 64'(tx_rises - r0), 64'(ns));
    chk("rsp_left", 64'(exp_rsp.size()), 0);
    chk("busy_after", bus.busy, 0);
    g_n.delete(); g_dir.delete(); g_w.delete(); g_rx.delete();
  endtask

  task automatic add_seq(input int n, input bit dir, input logic [63:0] w, input logic [63:0] rx);
    g_n.push_back(n); g_dir.push_back(dir); g_w.push_back(w); g_rx.push_back(rx);
  endtask

  initial begin
    int t;
    bus.start = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_tx_valid", bus.seq_tx_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_tx_cmd", bus.seq_tx_cmd, 0);
    chk("rst_tx_data", bus.seq_tx_data, 0);
    @(posedge clk); #1 reset = 1'b0;
    chk("pin_txdata", m_txdata(8, 64'hA5), 64'hA500_0000_0000_0000);
    chk("pin_rsp4", m_rspbyte(4, 64'hD, 0), 8'h0B);
    chk("pin_rsp64_first", m_rspbyte(64, 64'h0123_4567_89AB_CDEF, 0), 8'h80);
    chk("pin_rsp64_last", m_rspbyte(64, 64'h0123_4567_89AB_CDEF, 7), 8'hF7);

    add_seq(8, 0, 64'hA5, 64'h1234);
    run_txn(0);
    add_seq(4, 1, 64'h0, 64'hDEAD_BEEF_1234_567D);
    run_txn(0);
    add_seq(64, 1, 64'h0, 64'h0123_4567_89AB_CDEF);
    run_txn(1);
    add_seq(33, 0, {$urandom, $urandom}, 64'h0);
    add_seq(3, 1, 64'h0, {$urandom, $urandom});
    run_txn(0);

    rsp_hold = 1;
    @(posedge clk); #1;
    fork
      run_txn(0);
      begin
        repeat (12) @(negedge clk);
        chk("hold_valid", bus.rsp_valid, 1);
        chk("hold_data", bus.rsp_data, 8'h1D);
        rsp_hold = 0;
      end
    join

    hold_rx = 1;
    exp_rsp.push_back(8'h1D);
    exp_rsp.push_back(8'h00);
    exp_cmd.push_back(16'h2088);
    exp_txd.push_back(64'h0);
    rx_vals.push_back(64'h0);
    pulse_start();
    send_byte(8'd1);
    send_byte(8'h88);
    t = 0;
    while (!bus.seq_tx_valid && t < 200) begin @(negedge clk); t++; end
    chk("abort_tx_seen", bus.seq_tx_valid, 1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_tx_valid", bus.seq_tx_valid, 0);
    chk("abort_busy", bus.busy, 0);
    reset = 1'b0;
    exp_rsp.delete();
    hold_rx = 0;
    add_seq(8, 1, 64'h0, {$urandom, $urandom});
    run_txn(0);

    for (int i = 0; i < 25; i++) begin
      int cnt;
      cnt = $urandom_range(1, 4);
      for (int s = 0; s < cnt; s++)
        add_seq($urandom_range(1, 64), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
      run_txn(i % 5 == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
